// File: rtl/matrix_addsub_seq.sv
// Sequential signed matrix add/sub: LANES elements per cycle, optional saturation,
// start/busy/done handshake.

module matrix_addsub_lane #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [ELEM_W-1:0] res,
  output logic              ovf
);
  logic [ELEM_W:0] s;

  always_comb begin
    s   = sub ? {a[ELEM_W-1], a} - {b[ELEM_W-1], b}
              : {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
    ovf = s[ELEM_W] ^ s[ELEM_W-1];
    // Sign of the widened sum picks which rail to clamp to
    if (sat && ovf) res = s[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
    else            res = s[ELEM_W-1:0];
  end
endmodule

module matrix_addsub_seq #(
  parameter int ELEM_W  = 8,
  parameter int N_ELEMS = 25,
  parameter int LANES   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic                      saturate,
  input  logic [N_ELEMS*ELEM_W-1:0] matrix_A,
  input  logic [N_ELEMS*ELEM_W-1:0] matrix_B,
  output logic                      busy,
  output logic                      done,
  output logic [N_ELEMS*ELEM_W-1:0] result_out,
  output logic                      overflow
);
  localparam int IDX_W = $clog2(N_ELEMS + LANES + 1);
  localparam int EL_W  = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [N_ELEMS-1:0][ELEM_W-1:0] a_q, b_q, res_q;
  logic                           op_q, sat_q, ovf_q;
  logic [IDX_W-1:0]               idx;
  logic                           accept, last_chunk;

  logic [LANES-1:0]             lane_en, lane_ovf;
  logic [LANES-1:0][EL_W-1:0]   lane_sel;
  logic [LANES-1:0][ELEM_W-1:0] lane_a, lane_b, lane_res;

  assign accept     = start && (state == IDLE || state == DONE);
  assign last_chunk = (idx + IDX_W'(LANES)) >= IDX_W'(N_ELEMS);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] e;
    assign e           = idx + IDX_W'(l);
    // Lanes past the end of the matrix are gated off (partial last chunk)
    assign lane_en[l]  = (e < IDX_W'(N_ELEMS));
    assign lane_sel[l] = lane_en[l] ? EL_W'(e) : '0;
    assign lane_a[l]   = a_q[lane_sel[l]];
    assign lane_b[l]   = b_q[lane_sel[l]];

    matrix_addsub_lane #(.ELEM_W(ELEM_W)) u_lane (
      .a   (lane_a[l]),
      .b   (lane_b[l]),
      .sub (op_q),
      .sat (sat_q),
      .res (lane_res[l]),
      .ovf (lane_ovf[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      sat_q <= 1'b0;
      idx   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      // result_out is intentionally left alone here
      a_q   <= matrix_A;
      b_q   <= matrix_B;
      op_q  <= op_sub;
      sat_q <= saturate;
      idx   <= '0;
      ovf_q <= 1'b0;
    end else if (state == RUN) begin
      idx   <= idx + IDX_W'(LANES);
      ovf_q <= ovf_q | (|(lane_ovf & lane_en));
      for (int l = 0; l < LANES; l++)
        if (lane_en[l]) res_q[lane_sel[l]] <= lane_res[l];
    end
  end

  assign result_out = res_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: directed + random ops on LANES=5 and LANES=4 instances,
// checked against an integer-arithmetic reference model.

module tb_matrix_addsub_seq;
  localparam int W    = 8;
  localparam int N    = 25;
  localparam int MAXV = 127;
  localparam int MINV = -128;
  localparam int K5   = 5;
  localparam int K4   = 7;

  typedef logic [N*W-1:0] mat_t;

  logic clk = 1'b0;
  logic rst, start, start4, op_sub, saturate;
  mat_t mA, mB;
  logic busy, done, ovf, busy4, done4, ovf4;
  mat_t res, res4;

  int total = 0, passed = 0, failed = 0;
  mat_t prev5, prev4;

  always #5 clk = ~clk;

  matrix_addsub_seq #(.ELEM_W(W), .N_ELEMS(N), .LANES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .saturate(saturate),
    .matrix_A(mA), .matrix_B(mB), .busy(busy), .done(done),
    .result_out(res), .overflow(ovf)
  );

  matrix_addsub_seq #(.ELEM_W(W), .N_ELEMS(N), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(op_sub), .saturate(saturate),
    .matrix_A(mA), .matrix_B(mB), .busy(busy4), .done(done4),
    .result_out(res4), .overflow(ovf4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input mat_t obs, input mat_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mat_t fill(input logic [W-1:0] v);
    mat_t m;
    for (int i = 0; i < N; i++) m[i*W +: W] = v;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  // Element-wise reference: plain integer arithmetic, then range test
  function automatic void model(input mat_t a, input mat_t b, input bit op, input bit sat,
                                output mat_t r, output bit o);
    int x, y, s;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < N; i++) begin
      x = $signed(a[i*W +: W]);
      y = $signed(b[i*W +: W]);
      s = op ? x - y : x + y;
      if (s > MAXV || s < MINV) begin
        o = 1'b1;
        if (sat) s = (s > MAXV) ? MAXV : MINV;
      end
      r[i*W +: W] = s[W-1:0];
    end
  endfunction

  task automatic run_op(input bit sel, input mat_t a, input mat_t b, input bit op,
                        input bit sat, input string tag);
    mat_t er;
    bit   eo;
    int   k;
    k = sel ? K4 : K5;
    model(a, b, op, sat, er, eo);
    mA = a; mB = b; op_sub = op; saturate = sat;
    if (sel) start4 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start4 = 1'b0;
    // operands may change once latched
    mA = rand_mat(); mB = rand_mat(); op_sub = ~op; saturate = ~sat;
    check({tag, "_ovf_clr"}, sel ? ovf4 : ovf, 0);
    check({tag, "_res_hold"}, sel ? res4 : res, sel ? prev4 : prev5);
    for (int c = 1; c <= k; c++) begin
      check({tag, "_busy"}, sel ? busy4 : busy, 1);
      check({tag, "_done_lo"}, sel ? done4 : done, 0);
      step();
    end
    check({tag, "_done"}, sel ? done4 : done, 1);
    check({tag, "_busy_lo"}, sel ? busy4 : busy, 0);
    check({tag, "_result"}, sel ? res4 : res, er);
    check({tag, "_overflow"}, sel ? ovf4 : ovf, mat_t'(eo));
    if (sel) prev4 = er; else prev5 = er;
    step();
    check({tag, "_idle_done"}, sel ? done4 : done, 0);
    check({tag, "_held"}, sel ? res4 : res, er);
    check({tag, "_ovf_held"}, sel ? ovf4 : ovf, mat_t'(eo));
  endtask

  initial begin
    mat_t a, b, a1, a2, a3, bb, er1, er2;
    bit   eo1, eo2;

    rst = 1'b1; start = 1'b0; start4 = 1'b0; op_sub = 1'b0; saturate = 1'b0;
    mA = rand_mat(); mB = rand_mat();
    prev5 = '0; prev4 = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res", res, 0);
    check("rst_res4", res4, 0);
    check("rst_busy4", busy4, 0);

    // plain add -> all 0x7F
    run_op(0, fill(8'd100), fill(8'd27), 0, 0, "add");
    check("add_const", res, fill(8'h7F));

    // add overflow on element 0, wrap then saturate
    a = '0; b = '0; a[7:0] = 8'd100; b[7:0] = 8'd28;
    run_op(0, a, b, 0, 0, "addovf_wrap");
    check("addovf_wrap_e0", res[7:0], 8'h80);
    run_op(0, a, b, 0, 1, "addovf_sat");
    check("addovf_sat_e0", res[7:0], 8'h7F);

    // sub overflow on element 24
    a = '0; b = '0; a[24*W +: W] = 8'h9C; b[24*W +: W] = 8'd100;
    run_op(0, a, b, 1, 0, "subovf_wrap");
    check("subovf_wrap_e24", res[24*W +: W], 8'h38);
    run_op(0, a, b, 1, 1, "subovf_sat");
    check("subovf_sat_e24", res[24*W +: W], 8'h80);
    run_op(0, '0, '0, 0, 0, "noovf");

    // boundaries: min-min, 0-min
    run_op(0, fill(8'h80), fill(8'h80), 1, 1, "minmin");
    run_op(0, '0, fill(8'h80), 1, 1, "zero_minus_min");
    check("zmm_e7", res[7*W +: W], 8'h7F);

    for (int r = 0; r < 8; r++)
      run_op(r[0], rand_mat(), rand_mat(), 1'($urandom), 1'($urandom), "rand");

    // handshake: start pulse during RUN cycle 2 is ignored
    a1 = rand_mat(); a2 = rand_mat(); a3 = rand_mat(); bb = rand_mat();
    model(a1, bb, 0, 1, er1, eo1);
    model(a3, bb, 0, 1, er2, eo2);
    mA = a1; mB = bb; op_sub = 1'b0; saturate = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    mA = a2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 3; c <= K5; c++) begin
      check("hs_busy", busy, 1);
      step();
    end
    check("hs_done", done, 1);
    check("hs_result", res, er1);
    step();
    check("hs_idle", busy | done, 0);

    // back-to-back: start held high through DONE
    mA = a1; start = 1'b1;
    step();
    step();
    mA = a3;
    for (int c = 2; c < K5 + 1; c++) step();
    check("b2b_done1", done, 1);
    check("b2b_res1", res, er1);
    step();
    start = 1'b0;
    check("b2b_busy2", busy, 1);
    for (int c = 1; c <= K5; c++) begin
      check("b2b_done_gap", done, 0);
      step();
    end
    check("b2b_done2", done, 1);
    check("b2b_res2", res, er2);
    check("b2b_ovf2", ovf, mat_t'(eo2));
    prev5 = er2;
    step();

    // reset mid-op (RUN cycle 3), overflow already accumulated
    mA = '0; mB = fill(8'h80); op_sub = 1'b1; saturate = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_res", res, 0);
    step();
    check("mid_rst_stay_idle", busy | done, 0);
    prev5 = '0; prev4 = '0;
    run_op(0, rand_mat(), rand_mat(), 0, 1, "post_rst");

    // LANES=4: partial last chunk, element 24 saturates
    a = rand_mat(); b = rand_mat(); a[24*W +: W] = 8'd127; b[24*W +: W] = 8'd1;
    run_op(1, a, b, 0, 1, "l4_sat");
    check("l4_e24", res4[24*W +: W], 8'h7F);
    run_op(1, rand_mat(), rand_mat(), 1, 0, "l4_rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
